// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC generation, req/gnt fetch issue, in-order response buffering, redirect squash.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_squashed event counters.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    // state | meaning
    // IDLE  | no new fetches issued; in-flight responses and queue still drain
    // RUN   | fetches issued while credit (queued + outstanding < DEPTH) allows

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc_next, resp_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, outstanding, discard;
    logic [CW:0]   in_use;
    logic [31:0]   target;
    logic          grant, rsp, push, pop, drop;

    assign target = {redirect_pc[31:2], 2'b00};
    assign in_use = {1'b0, count} + {1'b0, outstanding};

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                imem_req = !redirect && (in_use < (CW+1)'(DEPTH));
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // responses arriving with nothing outstanding are leftovers from before a reset
    assign grant = imem_req && imem_gnt;
    assign rsp   = imem_rvalid && (outstanding != '0);
    assign drop  = rsp && (redirect || (discard != '0));
    assign push  = rsp && !redirect && (discard == '0);
    assign pop   = valid_d && !id_stall && !redirect;

    assign imem_addr = pc_next;
    assign valid_d   = (count != '0);
    assign instr_d   = valid_d ? q_instr[head] : 32'h0;
    assign pc_d      = valid_d ? q_pc[head]    : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_next     <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            // every word still in flight belongs to the squashed path
            pc_next     <= target;
            resp_pc     <= target;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
        end else begin
            if (grant) pc_next <= pc_next + 32'd4;
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (drop) discard <= discard - 1'b1;
            if (push) begin
                tail    <= tail + 1'b1;
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= 32'h0;
                q_instr[i] <= 32'h0;
            end
        end else if (push) begin
            q_pc[tail]    <= resp_pc;
            q_instr[tail] <= imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched  <= 32'h0;
            perf_squashed <= 32'h0;
        end else begin
            perf_fetched  <= perf_fetched + 32'(push);
            perf_squashed <= perf_squashed + (redirect ? 32'(count) : 32'h0) + 32'(drop);
        end
    end
`endif

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus multi-cycle sequences with a simple memory responder.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed;
    logic [31:0] sq_before;
`endif

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // memory word returned for an address
    localparam logic [31:0] TAG = 32'hDEAD_0000;

    typedef struct {
        logic        start, gnt, rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] pending[$];
    logic [31:0] granted[$];
    logic [31:0] popped_pc[$];
    logic [31:0] popped_instr[$];
    logic        hold, stray;
    logic        last_req, last_valid;
    logic [31:0] last_addr;
    int          n8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
        hold = 1'b0; stray = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        pending.delete(); granted.delete(); popped_pc.delete(); popped_instr.delete();
    endtask

    // one cycle from a negedge: responder drives rvalid, outputs are captured, grants/pops logged
    task automatic tick();
        if (stray) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
        end else if (!hold && pending.size() > 0) begin
            imem_rvalid = 1'b1; imem_rdata = pending.pop_front() ^ TAG;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = 32'h0;
        end
        #1;
        last_req = imem_req; last_addr = imem_addr; last_valid = valid_d;
        if (imem_req && imem_gnt) begin
            pending.push_back(imem_addr);
            granted.push_back(imem_addr);
        end
        if (valid_d && !id_stall && !redirect) begin
            popped_pc.push_back(pc_d);
            popped_instr.push_back(instr_d);
        end
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        //            start gnt rv rdata          stall req addr   valid pc     instr
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hDEAD0000, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hDEAD0004, 1'b0, 1'b1, 32'h8, 1'b1, 32'h0, 32'hDEAD0000};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hDEAD0008, 1'b0, 1'b1, 32'hC, 1'b1, 32'h4, 32'hDEAD0004};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hDEAD000C, 1'b0, 1'b1, 32'h10, 1'b1, 32'h8, 32'hDEAD0008};

        // streaming fetch with 1-cycle response latency
        do_reset();
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
            imem_rdata = vecs[i].rdata; id_stall = vecs[i].stall;
            #1;
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,         vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, valid_d},  {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i),    pc_d,              vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr_d,           vecs[i].e_instr);
            @(negedge clock);
        end

        // decode stalled: credit limits to 4 grants, then drains in order
        do_reset();
        start = 1'b1; imem_gnt = 1'b1; id_stall = 1'b1;
        ticks(10);
        chk("stall_grants", granted.size(), 4);
        chk("stall_req_off", {31'b0, last_req}, 32'h0);
        chk("stall_head_pc", pc_d, 32'h0);
        id_stall = 1'b0;
        ticks(8);
        chk("drain_n", {31'b0, popped_pc.size() >= 4}, 32'h1);
        for (int i = 0; i < 4; i++) chk($sformatf("drain_pc%0d", i), popped_pc[i], 32'(4 * i));
        chk("drain_instr3", popped_instr[3], 32'hC ^ TAG);
        chk("resume_addr", granted[4], 32'h10);

        // redirect with 2 queued and 2 outstanding
        do_reset();
        start = 1'b1; imem_gnt = 1'b1; id_stall = 1'b1;
        ticks(4);
        hold = 1'b1;
        ticks(2);
        chk("pre_redir_req", {31'b0, last_req}, 32'h0);
`ifdef IF_PERF_CNT_EN
        sq_before = perf_squashed;
`endif
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        chk("redir_req", {31'b0, last_req}, 32'h0);
        redirect = 1'b0; hold = 1'b0; id_stall = 1'b0;
        tick();
        chk("redir_valid", {31'b0, last_valid}, 32'h0);
        chk("redir_addr", last_addr, 32'h40);
        ticks(6);
        chk("redir_pop0_pc", popped_pc[0], 32'h40);
        chk("redir_pop0_instr", popped_instr[0], 32'h40 ^ TAG);
        chk("redir_pop1_pc", popped_pc[1], 32'h44);
`ifdef IF_PERF_CNT_EN
        chk("perf_squashed", perf_squashed - sq_before, 32'd4);
`endif

        // grant withheld for 3 cycles
        do_reset();
        start = 1'b1; imem_gnt = 1'b0;
        tick();
        imem_gnt = 1'b1;
        ticks(2);
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wait%0d_req", i), {31'b0, last_req}, 32'h1);
            chk($sformatf("wait%0d_addr", i), last_addr, 32'h8);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        ticks(5);
        n8 = 0;
        foreach (popped_pc[i]) if (popped_pc[i] == 32'h8) n8++;
        chk("gnt_wait_once", n8, 1);
        chk("gnt_wait_total", popped_pc.size(), 3);
        chk("gnt_wait_pc2", popped_pc[2], 32'h8);

        // reset mid-fetch, then a stray response
        do_reset();
        start = 1'b1; imem_gnt = 1'b1; hold = 1'b1;
        ticks(3);
        reset = 1'b1;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        pending.delete(); granted.delete();
        start = 1'b0; hold = 1'b0; stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("stray_valid", {31'b0, last_valid}, 32'h0);
        start = 1'b1;
        ticks(6);
        chk("restart_pc", popped_pc[0], 32'h0);
        chk("restart_instr", popped_instr[0], TAG);

        // back-to-back redirects, misaligned target, address wrap
        do_reset();
        start = 1'b1; imem_gnt = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        chk("b2b_req", {31'b0, last_req}, 32'h0);
        redirect = 1'b0;
        tick();
        chk("wrap_addr0", last_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", last_addr, 32'h0);
        ticks(4);
        chk("wrap_pop0", popped_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pop1", popped_pc[1], 32'h0);
        chk("wrap_instr1", popped_instr[1], TAG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
